decoder_8b10: RTL and testbench

- Receive-side counterpart of the 8b/10b encoder: converts one 10-bit code group per enabled cycle back to 8-bit data plus a K flag.
- Tracks running disparity (RD) and flags code-group and disparity violations.
- Keeps a saturating error counter for link monitoring.
- Sits after the deserializer/comma aligner, before the PCS receive logic.

---
 rtl/decoder_8b10.sv | 201 ++++++++++++++++++++
 tb/tb_decoder_8b10.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_8b10.sv
// 8b/10b receive decoder: converts one 10-bit code group per enabled cycle
// into a byte plus K flag, tracks running disparity, flags code and
// disparity violations and keeps a saturating error counter.
module decoder_8b10 #(
  parameter int   ERR_CNT_W = 8,
  parameter logic INIT_DISP = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [9:0]           din,
  input  logic                 err_clr,
  output logic [7:0]           dout,
  output logic                 kout,
  output logic                 dout_valid,
  output logic                 code_err,
  output logic                 disp_err,
  output logic                 disp,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // Ones count of the 6b sub-block.
  function automatic logic [2:0] ones6(input logic [5:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  // Ones count of the 4b sub-block.
  function automatic logic [2:0] ones4(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  // 5b/6b reverse table, both RD columns: {valid, k28, EDCBA}.
  function automatic logic [6:0] dec6(input logic [5:0] v);
    case (v)
      6'b100111, 6'b011000: return {2'b10, 5'd0};
      6'b011101, 6'b100010: return {2'b10, 5'd1};
      6'b101101, 6'b010010: return {2'b10, 5'd2};
      6'b110001:            return {2'b10, 5'd3};
      6'b110101, 6'b001010: return {2'b10, 5'd4};
      6'b101001:            return {2'b10, 5'd5};
      6'b011001:            return {2'b10, 5'd6};
      6'b111000, 6'b000111: return {2'b10, 5'd7};
      6'b111001, 6'b000110: return {2'b10, 5'd8};
      6'b100101:            return {2'b10, 5'd9};
      6'b010101:            return {2'b10, 5'd10};
      6'b110100:            return {2'b10, 5'd11};
      6'b001101:            return {2'b10, 5'd12};
      6'b101100:            return {2'b10, 5'd13};
      6'b011100:            return {2'b10, 5'd14};
      6'b010111, 6'b101000: return {2'b10, 5'd15};
      6'b011011, 6'b100100: return {2'b10, 5'd16};
      6'b100011:            return {2'b10, 5'd17};
      6'b010011:            return {2'b10, 5'd18};
      6'b110010:            return {2'b10, 5'd19};
      6'b001011:            return {2'b10, 5'd20};
      6'b101010:            return {2'b10, 5'd21};
      6'b011010:            return {2'b10, 5'd22};
      6'b111010, 6'b000101: return {2'b10, 5'd23};
      6'b110011, 6'b001100: return {2'b10, 5'd24};
      6'b100110:            return {2'b10, 5'd25};
      6'b010110:            return {2'b10, 5'd26};
      6'b110110, 6'b001001: return {2'b10, 5'd27};
      6'b001110:            return {2'b10, 5'd28};
      6'b101110, 6'b010001: return {2'b10, 5'd29};
      6'b011110, 6'b100001: return {2'b10, 5'd30};
      6'b101011, 6'b010100: return {2'b10, 5'd31};
      6'b001111, 6'b110000: return {2'b11, 5'd28};
      default:              return 7'd0;
    endcase
  endfunction

  // 3b/4b reverse table (data forms plus A7); returns HGF.
  function automatic logic [2:0] dec4(input logic [3:0] v);
    case (v)
      4'b1011, 4'b0100:                   return 3'd0;
      4'b1001:                            return 3'd1;
      4'b0101:                            return 3'd2;
      4'b1100, 4'b0011:                   return 3'd3;
      4'b1101, 4'b0010:                   return 3'd4;
      4'b1010:                            return 3'd5;
      4'b0110:                            return 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: return 3'd7;
      default:                            return 3'd0;
    endcase
  endfunction

  logic [2:0] n6_s, n4_s, y_s;
  logic [6:0] d6_s;
  logic [4:0] x_s;
  logic [3:0] f_eff_s;
  logic [7:0] dout_s;
  logic       v6_s, v4_s, k28_s, pos6_s, neg6_s, pos4_s, neg4_s;
  logic       rd4_s, rd_next_s, de_s, ce_s, kout_s, kset_ok_s, bad_pair_s;
  logic       x_a7n_s, x_a7p_s, x_k7_s, a7_s, same_sign_s, is_k_s;

  // Decode the code group, classify violations and compute the next RD.
  always_comb begin
    n6_s   = ones6(din[9:4]);
    n4_s   = ones4(din[3:0]);
    d6_s   = dec6(din[9:4]);
    v6_s   = d6_s[6];
    k28_s  = d6_s[5];
    x_s    = d6_s[4:0];
    v4_s   = (n4_s >= 3'd1) && (n4_s <= 3'd3);
    pos6_s = n6_s > 3'd3;
    neg6_s = n6_s < 3'd3;
    pos4_s = n4_s > 3'd2;
    neg4_s = n4_s < 3'd2;

    // RD seen by the 4b sub-block, then RD after the whole group.
    if (pos6_s)      rd4_s = 1'b1;
    else if (neg6_s) rd4_s = 1'b0;
    else             rd4_s = disp;
    if (pos4_s)      rd_next_s = 1'b1;
    else if (neg4_s) rd_next_s = 1'b0;
    else             rd_next_s = rd4_s;

    de_s = (n6_s == 3'd4 && disp) || (n6_s == 3'd2 && !disp) ||
           (din[9:4] == 6'b111000 && disp) || (din[9:4] == 6'b000111 && !disp) ||
           (n4_s == 3'd3 && rd4_s) || (n4_s == 3'd1 && !rd4_s) ||
           (din[3:0] == 4'b1100 && rd4_s) || (din[3:0] == 4'b0011 && !rd4_s);

    // After K.28 RD+ form the 4b K column is the complement of the RD- one,
    // so fold it onto a single table.
    if (din[9:4] == 6'b110000) f_eff_s = ~din[3:0];
    else                       f_eff_s = din[3:0];
    y_s = dec4(f_eff_s);

    case (f_eff_s)
      4'b0100, 4'b1001, 4'b0101, 4'b0011,
      4'b0010, 4'b1010, 4'b0110, 4'b1000: kset_ok_s = 1'b1;
      default:                            kset_ok_s = 1'b0;
    endcase

    x_a7n_s = (x_s == 5'd17) || (x_s == 5'd18) || (x_s == 5'd20);
    x_a7p_s = (x_s == 5'd11) || (x_s == 5'd13) || (x_s == 5'd14);
    x_k7_s  = (x_s == 5'd23) || (x_s == 5'd27) || (x_s == 5'd29) || (x_s == 5'd30);
    a7_s    = (din[3:0] == 4'b0111) || (din[3:0] == 4'b1000);

    // A7 is legal only where the encoder substitutes it or for K.x.7.
    if (k28_s) begin
      bad_pair_s = !kset_ok_s;
      is_k_s     = kset_ok_s;
    end else begin
      bad_pair_s = (din[3:0] == 4'b0111 && !(x_a7n_s || x_k7_s)) ||
                   (din[3:0] == 4'b1000 && !(x_a7p_s || x_k7_s)) ||
                   (din[3:0] == 4'b1110 && x_a7n_s) ||
                   (din[3:0] == 4'b0001 && x_a7p_s);
      is_k_s     = x_k7_s && a7_s;
    end

    // Both sub-blocks unbalanced the same way never occurs in a legal group.
    same_sign_s = (pos6_s && pos4_s) || (neg6_s && neg4_s);
    ce_s        = !v6_s || !v4_s || same_sign_s || bad_pair_s;

    if (v6_s && v4_s) dout_s = {y_s, x_s};
    else              dout_s = 8'h00;
    kout_s = is_k_s && !ce_s;
  end

  // Output and running-disparity registers, updated only on enabled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= 8'h00;
      kout       <= 1'b0;
      dout_valid <= 1'b0;
      code_err   <= 1'b0;
      disp_err   <= 1'b0;
      disp       <= INIT_DISP;
    end else if (en) begin
      dout       <= dout_s;
      kout       <= kout_s;
      dout_valid <= 1'b1;
      code_err   <= ce_s;
      disp_err   <= de_s;
      disp       <= rd_next_s;
    end else begin
      dout_valid <= 1'b0;
    end
  end

  // Saturating error counter; clear wins over a simultaneous increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (en && (ce_s || de_s) && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end else begin
      err_cnt <= err_cnt;
    end
  end

endmodule

// File: tb/tb_decoder_8b10.sv
// Directed bench for decoder_8b10: table of hand-computed vectors, mid-stream
// reset, counter saturation on a 2-bit instance, and an encoder loopback.
module tb_decoder_8b10;

  logic       clk = 1'b0;
  logic       rst, en, err_clr, en2, err_clr2;
  logic [9:0] din, din2;
  logic [7:0] dout, dout2;
  logic       kout, dout_valid, code_err, disp_err, disp;
  logic       kout2, dout_valid2, code_err2, disp_err2, disp2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decoder_8b10 dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .err_clr(err_clr),
    .dout(dout), .kout(kout), .dout_valid(dout_valid), .code_err(code_err),
    .disp_err(disp_err), .disp(disp), .err_cnt(err_cnt)
  );

  decoder_8b10 #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .din(din2), .err_clr(err_clr2),
    .dout(dout2), .kout(kout2), .dout_valid(dout_valid2), .code_err(code_err2),
    .disp_err(disp_err2), .disp(disp2), .err_cnt(err_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference encoder tables (RD- forms).
  localparam logic [5:0] T6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [3:0] T4 [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] K4 [8] = '{
    4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  localparam logic [7:0] KTAB [12] = '{
    8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  // Encode one byte; returns {rd_after, abcdei, fghj}.
  function automatic logic [10:0] enc(input logic [7:0] d, input logic k, input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] s;
    logic [3:0] f;
    logic       rd1, rd2, k28;
    x   = d[4:0];
    y   = d[7:5];
    k28 = k && (x == 5'd28);
    s   = k28 ? 6'b001111 : T6[x];
    if (rd && ($countones(s) != 3 || s == 6'b111000)) s = ~s;
    rd1 = ($countones(s) > 3) ? 1'b1 : ($countones(s) < 3) ? 1'b0 : rd;
    if (k28) f = K4[y];
    else if (y == 3'd7 && (k || (!rd1 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                           (rd1 && (x == 5'd11 || x == 5'd13 || x == 5'd14)))) f = 4'b0111;
    else f = T4[y];
    if (rd1 && (k28 || $countones(f) != 2 || f == 4'b1100)) f = ~f;
    rd2 = ($countones(f) > 2) ? 1'b1 : ($countones(f) < 2) ? 1'b0 : rd1;
    return {rd2, s, f};
  endfunction

  typedef struct {
    logic [9:0] din;
    logic       en;
    logic       clr;
    logic [7:0] dout;
    logic       kout;
    logic       valid;
    logic       ce;
    logic       de;
    logic       disp;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs [17];

  initial begin
    logic [10:0] e;
    logic [7:0]  d;
    logic        k, rd;

    vecs[0]  = '{10'b1001110100, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}; // D.0.0
    vecs[1]  = '{10'b0011111010, 1'b1, 1'b0, 8'hBC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0}; // K.28.5
    vecs[2]  = '{10'b0011111010, 1'b1, 1'b0, 8'hBC, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1}; // wrong RD
    vecs[3]  = '{10'b1010101010, 1'b1, 1'b0, 8'hB5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1}; // D.21.5 RD+
    vecs[4]  = '{10'b0000000000, 1'b0, 1'b1, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0}; // idle, clear
    vecs[5]  = '{10'b0000000000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[6]  = '{10'b1111111111, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2};
    vecs[7]  = '{10'b1100000101, 1'b1, 1'b0, 8'hBC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2}; // K.28.5 RD+
    vecs[8]  = '{10'b1010101010, 1'b1, 1'b0, 8'hB5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2}; // D.21.5 RD-
    vecs[9]  = '{10'b0000000000, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}; // clr wins
    vecs[10] = '{10'b1000110111, 1'b1, 1'b0, 8'hF1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0}; // D.17.7 A7
    vecs[11] = '{10'b1101000001, 1'b1, 1'b0, 8'hEB, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1}; // D.11 P7 misuse
    vecs[12] = '{10'b1110101000, 1'b1, 1'b0, 8'hF7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1}; // K.23.7
    vecs[13] = '{10'b0011110001, 1'b1, 1'b0, 8'hFC, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2}; // K.28 bad 4b
    vecs[14] = '{10'b0001110011, 1'b1, 1'b0, 8'h67, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3}; // D.7.3 RD+ form at RD-
    vecs[15] = '{10'b1110001100, 1'b0, 1'b0, 8'h67, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3}; // idle, hold
    vecs[16] = '{10'b1110001100, 1'b1, 1'b0, 8'h67, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3}; // D.7.3 RD-

    rst = 1'b1; en = 1'b0; err_clr = 1'b0; din = 10'd0;
    en2 = 1'b0; err_clr2 = 1'b0; din2 = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_kout", 32'(kout), 32'h0);
    chk("rst_valid", 32'(dout_valid), 32'h0);
    chk("rst_code_err", 32'(code_err), 32'h0);
    chk("rst_disp_err", 32'(disp_err), 32'h0);
    chk("rst_disp", 32'(disp), 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);

    for (int i = 0; i < 17; i++) begin
      din = vecs[i].din; en = vecs[i].en; err_clr = vecs[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_dout", i), 32'(dout), 32'(vecs[i].dout));
      chk($sformatf("v%0d_kout", i), 32'(kout), 32'(vecs[i].kout));
      chk($sformatf("v%0d_valid", i), 32'(dout_valid), 32'(vecs[i].valid));
      chk($sformatf("v%0d_code_err", i), 32'(code_err), 32'(vecs[i].ce));
      chk($sformatf("v%0d_disp_err", i), 32'(disp_err), 32'(vecs[i].de));
      chk($sformatf("v%0d_disp", i), 32'(disp), 32'(vecs[i].disp));
      chk($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(vecs[i].cnt));
    end
    err_clr = 1'b0;

    // Reset mid-stream while a K.28.5 (RD-) is presented: it must be dropped.
    rst = 1'b1; en = 1'b1; din = 10'b0011111010;
    @(posedge clk);
    #1;
    rst = 1'b0; en = 1'b0;
    chk("mid_rst_dout", 32'(dout), 32'h0);
    chk("mid_rst_kout", 32'(kout), 32'h0);
    chk("mid_rst_valid", 32'(dout_valid), 32'h0);
    chk("mid_rst_disp", 32'(disp), 32'h0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'h0);

    // 2-bit counter saturates at 3.
    en2 = 1'b1; din2 = 10'b0000000000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d_code_err", i), 32'(code_err2), 32'h1);
      chk($sformatf("sat%0d_err_cnt", i), 32'(err_cnt2), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    en2 = 1'b0;

    // Loopback through the reference encoder, with periodic idle gaps.
    rd = 1'b0;
    for (int i = 0; i < 268; i++) begin
      if (i % 9 == 8) begin
        en = 1'b0; din = 10'h3FF;
        @(posedge clk);
        #1;
        chk($sformatf("lb_gap%0d_valid", i), 32'(dout_valid), 32'h0);
        chk($sformatf("lb_gap%0d_disp", i), 32'(disp), 32'(rd));
      end
      if (i < 256) begin
        d = 8'(i);
        k = 1'b0;
      end else begin
        d = KTAB[i - 256];
        k = 1'b1;
      end
      e  = enc(d, k, rd);
      rd = e[10];
      en = 1'b1; din = e[9:0];
      @(posedge clk);
      #1;
      chk($sformatf("lb%0d_dout", i), 32'(dout), 32'(d));
      chk($sformatf("lb%0d_kout", i), 32'(kout), 32'(k));
      chk($sformatf("lb%0d_valid", i), 32'(dout_valid), 32'h1);
      chk($sformatf("lb%0d_err", i), 32'({code_err, disp_err}), 32'h0);
      chk($sformatf("lb%0d_disp", i), 32'(disp), 32'(rd));
    end
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("lb_final_err_cnt", 32'(err_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
